cache_ctrl: RTL and testbench

CACHE_CTRL -- requirements
Module: cache_ctrl

---
 rtl/cache_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_cache_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// Direct-mapped write-back cache controller: 8 lines x 4 words x 16 bits.
// Hits complete in the request cycle; misses write back a dirty victim word
// by word, refill the line word by word, then respond from the filled line.
module cache_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        done,
    output logic        stall,
    output logic        cache_hit,
    output logic        cache_req,
    output logic        err,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StWb, StFill, StResp} state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;

    logic [15:0] data_q [8][4];
    logic [9:0]  tag_q  [8];
    logic [7:0]  valid_q;
    logic [7:0]  dirty_q;

    // Address fields of the access being served (held stable while stalled)
    logic [2:0]  idx;
    logic [1:0]  word;
    logic [9:0]  atag;
    logic        req;
    logic        is_wr;
    logic        line_hit;

    assign idx      = addr[5:3];
    assign word     = addr[2:1];
    assign atag     = addr[15:6];
    assign req      = rd | wr;
    assign is_wr    = wr;
    assign line_hit = valid_q[idx] && (tag_q[idx] == atag);

    // Array write controls produced by the FSM
    logic        data_we;
    logic [1:0]  data_wsel;
    logic [15:0] data_wval;
    logic        fill_done;
    logic        set_dirty;
    logic        clr_valid;

    // Next-state, array controls and all outputs
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_we   = 1'b0;
        data_wsel = word;
        data_wval = wdata;
        fill_done = 1'b0;
        set_dirty = 1'b0;
        clr_valid = 1'b0;
        rdata     = '0;
        done      = 1'b0;
        stall     = 1'b0;
        cache_hit = 1'b0;
        cache_req = 1'b0;
        err       = 1'b0;
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    cache_req = 1'b1;
                    if (addr[0]) begin
                        done = 1'b1;
                        err  = 1'b1;
                    end else if (line_hit) begin
                        done      = 1'b1;
                        cache_hit = 1'b1;
                        if (is_wr) begin
                            data_we   = 1'b1;
                            set_dirty = 1'b1;
                        end else begin
                            rdata = data_q[idx][word];
                        end
                    end else begin
                        stall = 1'b1;
                        cnt_d = 2'd0;
                        // Line contents are about to be replaced
                        clr_valid = 1'b1;
                        state_d = (valid_q[idx] && dirty_q[idx]) ? StWb : StFill;
                    end
                end
            end
            StWb: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = {tag_q[idx], idx, cnt_q, 1'b0};
                mem_wdata = data_q[idx][cnt_q];
                if (mem_ack) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = StFill;
                    end
                end
            end
            StFill: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {atag, idx, cnt_q, 1'b0};
                if (mem_ack) begin
                    data_we   = 1'b1;
                    data_wsel = cnt_q;
                    data_wval = mem_rdata;
                    cnt_d     = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        fill_done = 1'b1;
                        state_d   = StResp;
                    end
                end
            end
            StResp: begin
                done = 1'b1;
                if (is_wr) begin
                    data_we   = 1'b1;
                    set_dirty = 1'b1;
                end else begin
                    rdata = data_q[idx][word];
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Outputs are silent while reset is held
        if (!rst_n) begin
            rdata     = '0;
            done      = 1'b0;
            stall     = 1'b0;
            cache_hit = 1'b0;
            cache_req = 1'b0;
            err       = 1'b0;
            mem_req   = 1'b0;
            mem_wr    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

    // FSM state and word counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Per-line valid and dirty bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (clr_valid) begin
                valid_q[idx] <= 1'b0;
            end
            if (fill_done) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end
            if (set_dirty) begin
                dirty_q[idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; valid bits qualify them
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_q[idx][data_wsel] <= data_wval;
        end
        if (fill_done) begin
            tag_q[idx] <= atag;
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: directed scenarios plus random accesses
// scored against a line-level cache model and a word-array backing memory.
module tb_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] wdata = '0;
    logic [15:0] rdata;
    logic        done, stall, cache_hit, cache_req, err;
    logic        mem_req, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;

    cache_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd        (rd),
        .wr        (wr),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .done      (done),
        .stall     (stall),
        .cache_hit (cache_hit),
        .cache_req (cache_req),
        .err       (err),
        .mem_req   (mem_req),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Backing memory and transfer log {wr, addr, data}
    logic [15:0] mem_arr [0:32767];
    logic [32:0] log_q [$];
    logic        hold_ack = 1'b0;

    // Memory responder: random-latency ack decided on the falling edge
    always @(negedge clk) begin
        if (rst_n && mem_req && !hold_ack && ($urandom_range(0, 2) != 0)) mem_ack = 1'b1;
        else mem_ack = 1'b0;
        mem_rdata = mem_arr[mem_addr[15:1]];
        if (mem_ack) begin
            log_q.push_back({mem_wr, mem_addr, mem_wr ? mem_wdata : mem_rdata});
            if (mem_wr) mem_arr[mem_addr[15:1]] = mem_wdata;
        end
    end

    // Reference cache model
    logic        mvalid [8];
    logic        mdirty [8];
    logic [9:0]  mtag   [8];
    logic [15:0] mdata  [8][4];

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            mvalid[i] = 1'b0;
            mdirty[i] = 1'b0;
        end
    endtask

    task automatic access(input logic r, input logic w, input logic [15:0] a,
                          input logic [15:0] d, input string tag);
        logic [2:0]  idx = a[5:3];
        logic [1:0]  wd = a[2:1];
        logic [9:0]  t = a[15:6];
        logic        mis = a[0];
        logic        hit = !mis && mvalid[idx] && (mtag[idx] == t);
        logic        wb = !mis && !hit && mvalid[idx] && mdirty[idx];
        logic        is_read = r && !w;
        logic [15:0] exp_rd;
        logic [32:0] exp_q [$];
        int          reqs = 0;
        int          hits = 0;
        int          stall_bad = 0;
        int          saw_done = 0;
        logic        st0 = 1'b0;
        logic        got_err = 1'b0, got_mreq = 1'b0;
        logic [15:0] got_rd = '0;

        if (wb) begin
            for (int k = 0; k < 4; k++)
                exp_q.push_back({1'b1, mtag[idx], idx, 2'(k), 1'b0, mdata[idx][k]});
        end
        if (!mis && !hit) begin
            for (int k = 0; k < 4; k++)
                exp_q.push_back({1'b0, t, idx, 2'(k), 1'b0, mem_arr[{t, idx, 2'(k)}]});
        end
        exp_rd = hit ? mdata[idx][wd] : mem_arr[{t, idx, wd}];
        // Advance the model to the post-access state
        if (!mis) begin
            if (!hit) begin
                for (int k = 0; k < 4; k++) mdata[idx][k] = mem_arr[{t, idx, 2'(k)}];
                mvalid[idx] = 1'b1;
                mtag[idx]   = t;
                mdirty[idx] = 1'b0;
            end
            if (w) begin
                mdata[idx][wd] = d;
                mdirty[idx]    = 1'b1;
            end
        end

        @(posedge clk);
        #1;
        rd = r; wr = w; addr = a; wdata = d;
        log_q.delete();
        for (int cyc = 0; cyc < 200; cyc++) begin
            #2;
            if (cyc == 0) st0 = stall;
            reqs += int'(cache_req);
            hits += int'(cache_hit);
            if (stall !== !done) stall_bad++;
            if (done) begin
                saw_done = 1;
                got_err  = err;
                got_rd   = rdata;
                got_mreq = mem_req;
                break;
            end
            @(posedge clk);
            #1;
        end
        check({tag, ".done"}, 33'(saw_done), 33'd1);
        check({tag, ".err"}, 33'(got_err), 33'(mis));
        check({tag, ".cache_req_cnt"}, 33'(reqs), 33'd1);
        check({tag, ".cache_hit_cnt"}, 33'(hits), 33'(hit));
        check({tag, ".stall"}, 33'(stall_bad), 33'd0);
        check({tag, ".stall_first"}, 33'(st0), 33'(!mis && !hit));
        check({tag, ".mem_req_done"}, 33'(got_mreq), 33'd0);
        if (is_read && !mis) check({tag, ".rdata"}, 33'(got_rd), 33'(exp_rd));
        check({tag, ".xfers"}, 33'(log_q.size()), 33'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < log_q.size(); k++)
            check({tag, ".xfer"}, log_q[k], exp_q[k]);
        @(posedge clk);
        #1;
        rd = 1'b0; wr = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        rd = 1'b1; addr = 16'h0003;
        model_reset();
        #3;
        check("reset.ctrl", 33'({done, err, stall, cache_req, cache_hit, mem_req, mem_wr}), 33'd0);
        check("reset.buses", 33'({rdata, mem_addr} ^ {16'h0, mem_wdata}), 33'd0);
        repeat (2) @(posedge clk);
        #1;
        rd = 1'b0; addr = '0;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] a0;
        logic [15:0] fill_addr;
        for (int i = 0; i < 32768; i++) mem_arr[i] = 16'($urandom);

        apply_reset();

        // Cold read miss, then write/read hits, then dirty eviction
        access(1'b1, 1'b0, 16'h0042, 16'h0000, "cold_rd");
        access(1'b0, 1'b1, 16'h0044, 16'hBEEF, "wr_hit");
        access(1'b1, 1'b0, 16'h0044, 16'h0000, "rd_hit");
        check("beef_model", 33'(mdata[0][2]), 33'h0BEEF);
        access(1'b1, 1'b0, 16'h0444, 16'h0000, "evict_rd");
        access(1'b1, 1'b0, 16'h0003, 16'h0000, "misalign");
        // rd+wr together on a hit acts as a write; eviction exposes the dirty line
        access(1'b1, 1'b1, 16'h0446, 16'h1234, "rdwr_hit");
        access(1'b1, 1'b0, 16'h0040, 16'h0000, "evict_rdwr");

        // Stalled fill, then reset in the middle of it
        apply_reset();
        fill_addr = 16'h0152;
        hold_ack = 1'b1;
        @(posedge clk);
        #1;
        rd = 1'b1; addr = fill_addr;
        @(posedge clk);
        #3;
        a0 = mem_addr;
        check("hold.mem_req", 33'({mem_req, mem_wr}), 33'b10);
        check("hold.addr0", 33'(a0), 33'({fill_addr[15:3], 3'b000}));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #3;
            check("hold.addr_stable", 33'(mem_addr), 33'(a0));
            check("hold.stall", 33'(stall), 33'd1);
        end
        rst_n = 1'b0;
        #1;
        check("rst_mid.mem_req", 33'(mem_req), 33'd0);
        check("rst_mid.stall", 33'(stall), 33'd0);
        model_reset();
        rd = 1'b0;
        hold_ack = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        access(1'b1, 1'b0, fill_addr, 16'h0000, "reread_miss");

        // Random mix over a few tags so hits, misses and evictions all occur
        for (int n = 0; n < 80; n++) begin
            logic [15:0] ra;
            logic [1:0]  op;
            ra = {10'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 9) == 0)};
            op = 2'($urandom_range(0, 2));
            access(op != 2'd1, op != 2'd0, ra, 16'($urandom), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
